// File: rtl/fifo_wptr_full.sv
// Write-side pointer and full-flag stage of an async FIFO: binary write pointer, RAM strobe/address,
// registered Gray write pointer for the read domain, and full/level against the synchronized read pointer.
module fifo_wptr_full #(
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [ADDR_WIDTH:0]   rq2_rptr_gray,
    output logic [ADDR_WIDTH:0]   wptr_gray,
    output logic                  full,
    output logic [ADDR_WIDTH:0]   wr_level
);

    localparam int PW = ADDR_WIDTH + 1;

    function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b = g;
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [PW-1:0] wbin_q, wbin_d;
    logic [PW-1:0] gray_q, gray_d;
    logic          full_q, full_d;
    logic [PW-1:0] level_q, level_d;
    logic [PW-1:0] rbin_s;
    logic [PW-1:0] full_target_s;

    // Handshake depends only on the registered full flag; writes are suppressed while in reset.
    always_comb begin
        wr_ready = ~full_q;
        wr_en    = wr_valid & ~full_q & ~rst;
    end

    // Next-state: pointer advance, its Gray image, and full/level against the synced read pointer.
    always_comb begin
        wbin_d = wbin_q;
        if (wr_en) begin
            wbin_d = wbin_q + PW'(1);
        end else begin
            wbin_d = wbin_q;
        end
        rbin_s        = gray2bin(rq2_rptr_gray);
        gray_d        = bin2gray(wbin_d);
        // Full when the write pointer is exactly one lap ahead: top two Gray bits inverted.
        full_target_s = {~rq2_rptr_gray[ADDR_WIDTH:ADDR_WIDTH-1], rq2_rptr_gray[ADDR_WIDTH-2:0]};
        full_d        = (gray_d == full_target_s);
        level_d       = wbin_d - rbin_s;
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wbin_q  <= '0;
            gray_q  <= '0;
            full_q  <= 1'b0;
            level_q <= '0;
        end else begin
            wbin_q  <= wbin_d;
            gray_q  <= gray_d;
            full_q  <= full_d;
            level_q <= level_d;
        end
    end

    assign wr_addr   = wbin_q[ADDR_WIDTH-1:0];
    assign wptr_gray = gray_q;
    assign full      = full_q;
    assign wr_level  = level_q;

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Scoreboard bench for fifo_wptr_full (ADDR_WIDTH=4): a reference model pushes the expected post-edge
// state each cycle and each scenario task pops and compares after the edge.
module tb_fifo_wptr_full;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_valid = 1'b0;
    logic       wr_ready;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [4:0] rq2_rptr_gray = 5'd0;
    logic [4:0] wptr_gray;
    logic       full;
    logic [4:0] wr_level;

    fifo_wptr_full #(.ADDR_WIDTH(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .wr_valid      (wr_valid),
        .wr_ready      (wr_ready),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .rq2_rptr_gray (rq2_rptr_gray),
        .wptr_gray     (wptr_gray),
        .full          (full),
        .wr_level      (wr_level)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0] g;
        logic       f;
        logic [4:0] lvl;
        logic [3:0] a;
    } exp_t;

    exp_t       sb[$];
    logic [4:0] m_wbin = 5'd0;
    logic       m_full = 1'b0;
    int         vectors = 0;
    int         miscompares = 0;

    function automatic logic [4:0] g_of(input logic [4:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [4:0] b_of(input logic [4:0] g);
        logic [4:0] b;
        b[4] = g[4];
        for (int i = 3; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    // Drive one cycle's inputs and push the model's expected post-edge state.
    task automatic step(input logic r, input logic v, input logic [4:0] rq,
                        output logic acc, output logic [3:0] addr_pre);
        logic [4:0] nb;
        logic [4:0] lvl;
        exp_t       e;
        rst = r; wr_valid = v; rq2_rptr_gray = rq;
        #1;
        addr_pre = m_wbin[3:0];
        acc = v & ~r & ~m_full;
        if (r) nb = 5'd0;
        else   nb = acc ? m_wbin + 5'd1 : m_wbin;
        lvl = r ? 5'd0 : nb - b_of(rq);
        e.g = g_of(nb);
        e.f = ~r & (lvl == 5'd16);
        e.lvl = lvl;
        e.a = nb[3:0];
        sb.push_back(e);
        m_wbin = nb;
        m_full = e.f;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        logic acc; logic [3:0] ap; exp_t e;
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b1, 5'd0, acc, ap);
            vectors++;
            if (wr_en !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_wr_en: got %b expected 0", wr_en);
            end
            tick();
            e = sb.pop_front();
            vectors++;
            if ({wptr_gray, full, wr_level, wr_addr, wr_ready} !== {e.g, e.f, e.lvl, e.a, 1'b1}) begin
                miscompares++;
                $display("FAIL reset_state: got g=%b f=%b lvl=%0d a=%0d rdy=%b expected g=%b f=%b lvl=%0d a=%0d rdy=1",
                         wptr_gray, full, wr_level, wr_addr, wr_ready, e.g, e.f, e.lvl, e.a);
            end
        end
    endtask

    task automatic test_fill;
        logic acc; logic [3:0] ap; exp_t e;
        for (int i = 0; i < 17; i++) begin
            step(1'b0, 1'b1, 5'd0, acc, ap);
            vectors++;
            if (wr_en !== acc || wr_addr !== ap) begin
                miscompares++;
                $display("FAIL fill_pre[%0d]: got en=%b a=%0d expected en=%b a=%0d", i, wr_en, wr_addr, acc, ap);
            end
            tick();
            e = sb.pop_front();
            vectors++;
            if ({wptr_gray, full, wr_level, wr_addr} !== {e.g, e.f, e.lvl, e.a}) begin
                miscompares++;
                $display("FAIL fill_post[%0d]: got g=%b f=%b lvl=%0d a=%0d expected g=%b f=%b lvl=%0d a=%0d",
                         i, wptr_gray, full, wr_level, wr_addr, e.g, e.f, e.lvl, e.a);
            end
        end
        vectors++;
        if (wptr_gray !== 5'b11000 || full !== 1'b1 || wr_level !== 5'd16 || wr_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL fill_final: got g=%b f=%b lvl=%0d rdy=%b expected g=11000 f=1 lvl=16 rdy=0",
                     wptr_gray, full, wr_level, wr_ready);
        end
    endtask

    task automatic test_read_release;
        logic acc; logic [3:0] ap; exp_t e;
        step(1'b0, 1'b0, 5'b00001, acc, ap);
        tick();
        e = sb.pop_front();
        vectors++;
        if (full !== 1'b0 || wr_level !== 5'd15 || {wptr_gray, full, wr_level, wr_addr} !== {e.g, e.f, e.lvl, e.a}) begin
            miscompares++;
            $display("FAIL release_post: got f=%b lvl=%0d expected f=0 lvl=15", full, wr_level);
        end
        step(1'b0, 1'b1, 5'b00001, acc, ap);
        vectors++;
        if (wr_en !== 1'b1 || wr_addr !== 4'd0) begin
            miscompares++;
            $display("FAIL release_write: got en=%b a=%0d expected en=1 a=0", wr_en, wr_addr);
        end
        tick();
        e = sb.pop_front();
        vectors++;
        if (full !== 1'b1 || {wptr_gray, full, wr_level, wr_addr} !== {e.g, e.f, e.lvl, e.a}) begin
            miscompares++;
            $display("FAIL refull: got g=%b f=%b lvl=%0d expected g=%b f=1 lvl=%0d", wptr_gray, full, wr_level, e.g, e.lvl);
        end
    endtask

    task automatic test_full_read_same_cycle;
        logic acc; logic [3:0] ap; exp_t e;
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b1, g_of(5'd2), acc, ap);
            vectors++;
            if (wr_en !== (i == 1) || wr_en !== acc || wr_addr !== 4'd1) begin
                miscompares++;
                $display("FAIL pessimistic_pre[%0d]: got en=%b a=%0d expected en=%b a=1", i, wr_en, wr_addr, acc);
            end
            tick();
            e = sb.pop_front();
            vectors++;
            if ({wptr_gray, full, wr_level, wr_addr} !== {e.g, e.f, e.lvl, e.a}) begin
                miscompares++;
                $display("FAIL pessimistic_post[%0d]: got g=%b f=%b lvl=%0d a=%0d expected g=%b f=%b lvl=%0d a=%0d",
                         i, wptr_gray, full, wr_level, wr_addr, e.g, e.f, e.lvl, e.a);
            end
        end
    endtask

    task automatic test_mid_reset;
        logic acc; logic [3:0] ap; exp_t e;
        step(1'b0, 1'b0, g_of(5'd11), acc, ap);
        tick();
        e = sb.pop_front();
        vectors++;
        if (wr_level !== 5'd7 || {wptr_gray, full, wr_level, wr_addr} !== {e.g, e.f, e.lvl, e.a}) begin
            miscompares++;
            $display("FAIL level7: got lvl=%0d f=%b expected lvl=7 f=%b", wr_level, full, e.f);
        end
        step(1'b1, 1'b1, g_of(5'd11), acc, ap);
        tick();
        e = sb.pop_front();
        vectors++;
        if ({wptr_gray, full, wr_level, wr_addr} !== {5'd0, 1'b0, 5'd0, 4'd0} ||
            {wptr_gray, full, wr_level, wr_addr} !== {e.g, e.f, e.lvl, e.a}) begin
            miscompares++;
            $display("FAIL mid_reset: got g=%b f=%b lvl=%0d a=%0d expected all zero", wptr_gray, full, wr_level, wr_addr);
        end
    endtask

    task automatic test_wrap;
        logic acc; logic [3:0] ap; exp_t e; logic [4:0] prev; int wraps;
        wraps = 0;
        for (int i = 0; i < 40; i++) begin
            prev = wptr_gray;
            step(1'b0, 1'b1, g_of(m_wbin - 5'd4), acc, ap);
            vectors++;
            if (wr_en !== acc || wr_addr !== ap) begin
                miscompares++;
                $display("FAIL wrap_pre[%0d]: got en=%b a=%0d expected en=%b a=%0d", i, wr_en, wr_addr, acc, ap);
            end
            tick();
            e = sb.pop_front();
            vectors++;
            if ({wptr_gray, full, wr_level, wr_addr} !== {e.g, e.f, e.lvl, e.a} || $countones(wptr_gray ^ prev) != 1) begin
                miscompares++;
                $display("FAIL wrap_post[%0d]: got g=%b (prev %b) f=%b lvl=%0d a=%0d expected g=%b f=%b lvl=%0d a=%0d",
                         i, wptr_gray, prev, full, wr_level, wr_addr, e.g, e.f, e.lvl, e.a);
            end
            if (prev == 5'b10000) begin
                wraps++;
                vectors++;
                if (wptr_gray !== 5'b00000 || wr_addr !== 4'd0) begin
                    miscompares++;
                    $display("FAIL wrap_edge: got g=%b a=%0d expected g=00000 a=0", wptr_gray, wr_addr);
                end
            end
        end
        vectors++;
        if (wraps != 1) begin
            miscompares++;
            $display("FAIL wrap_count: got %0d expected 1", wraps);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_read_release();
        test_full_read_same_cycle();
        test_mid_reset();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
